// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the LC-3b pipeline hazard controller.
// Barrier control bundles are packed so each pipeline situation maps to one named constant.
package pipeline_hazard_controller_pkg;

    typedef logic [2:0] lc3b_reg;
    typedef logic [1:0] lc3b_hazard_state;

    localparam lc3b_hazard_state HZ_RUN    = 2'd0;
    localparam lc3b_hazard_state HZ_DWAIT  = 2'd1;
    localparam lc3b_hazard_state HZ_IDRAIN = 2'd2;

    typedef struct packed {
        logic pc_load;
        logic pc_redirect;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } hz_ctrl_t;

    // Field order: pc_load, pc_redirect, stalls IF/ID..MEM/WB, flushes IF/ID..EX/MEM
    localparam hz_ctrl_t CTRL_GO        = 9'b1_0_0000_000;
    localparam hz_ctrl_t CTRL_STALL_ALL = 9'b0_0_1111_000;
    localparam hz_ctrl_t CTRL_REDIRECT  = 9'b1_1_0000_111;
    localparam hz_ctrl_t CTRL_LOAD_USE  = 9'b0_0_1000_010;
    localparam hz_ctrl_t CTRL_IBUBBLE   = 9'b0_0_0000_100;

    function automatic logic any_stall(hz_ctrl_t c);
        return c.stall_if_id | c.stall_id_ex | c.stall_ex_mem | c.stall_mem_wb;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-status inputs from the pipeline and barrier/PC controls back to it.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_controller_if;
    import pipeline_hazard_controller_pkg::*;

    logic    if_req;
    logic    if_resp;
    logic    mem_req;
    logic    mem_resp;
    logic    ex_load;
    lc3b_reg ex_dest;
    lc3b_reg id_sr1;
    lc3b_reg id_sr2;
    logic    id_sr1_use;
    logic    id_sr2_use;
    logic    mem_br_taken;

    logic    pc_load;
    logic    pc_redirect;
    logic    stall_if_id;
    logic    stall_id_ex;
    logic    stall_ex_mem;
    logic    stall_mem_wb;
    logic    flush_if_id;
    logic    flush_id_ex;
    logic    flush_ex_mem;

    modport master (
        output if_req, if_resp, mem_req, mem_resp, ex_load, ex_dest,
               id_sr1, id_sr2, id_sr1_use, id_sr2_use, mem_br_taken,
        input  pc_load, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem,
               stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem
    );

    modport slave (
        input  if_req, if_resp, mem_req, mem_resp, ex_load, ex_dest,
               id_sr1, id_sr2, id_sr1_use, id_sr2_use, mem_br_taken,
        output pc_load, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem,
               stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem
    );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipeline_hazard_controller_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline: D/I-memory waits, load-use bubbles and
// MEM-stage redirects, with saturating stall-cycle and redirect-event counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   hz,
    output logic [CNT_WIDTH-1:0]          stall_cnt,
    output logic [CNT_WIDTH-1:0]          flush_cnt
);

    lc3b_hazard_state state_q, state_d;
    hz_ctrl_t         ctrl;
    logic             redirect;
    logic             i_wait;
    logic             load_use;
    logic             d_wait;

    assign i_wait   = hz.if_req & ~hz.if_resp;
    assign load_use = hz.ex_load & ((hz.id_sr1_use & (hz.id_sr1 == hz.ex_dest)) |
                                    (hz.id_sr2_use & (hz.id_sr2 == hz.ex_dest)));
    // Once in DWAIT the pending access stays outstanding until mem_resp, whatever mem_req says.
    assign d_wait   = ((state_q == HZ_DWAIT) | hz.mem_req) & ~hz.mem_resp;

    always_comb begin
        state_d  = state_q;
        ctrl     = CTRL_GO;
        redirect = 1'b0;
        case (state_q)
            HZ_IDRAIN: begin
                // Redirect only once the in-flight fetch lands; that instruction is discarded.
                if (hz.if_resp) begin
                    ctrl     = CTRL_REDIRECT;
                    redirect = 1'b1;
                    state_d  = HZ_RUN;
                end else begin
                    ctrl = CTRL_STALL_ALL;
                end
            end
            default: begin
                if (d_wait) begin
                    ctrl    = CTRL_STALL_ALL;
                    state_d = HZ_DWAIT;
                end else begin
                    state_d = HZ_RUN;
                    if (hz.mem_br_taken) begin
                        if (i_wait) begin
                            ctrl    = CTRL_STALL_ALL;
                            state_d = HZ_IDRAIN;
                        end else begin
                            ctrl     = CTRL_REDIRECT;
                            redirect = 1'b1;
                        end
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end else if (i_wait) begin
                        ctrl = CTRL_IBUBBLE;
                    end
                end
            end
        endcase
        if (reset) begin
            ctrl     = '0;
            redirect = 1'b0;
            state_d  = HZ_RUN;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign hz.pc_load      = ctrl.pc_load;
    assign hz.pc_redirect  = ctrl.pc_redirect;
    assign hz.stall_if_id  = ctrl.stall_if_id;
    assign hz.stall_id_ex  = ctrl.stall_id_ex;
    assign hz.stall_ex_mem = ctrl.stall_ex_mem;
    assign hz.stall_mem_wb = ctrl.stall_mem_wb;
    assign hz.flush_if_id  = ctrl.flush_if_id;
    assign hz.flush_id_ex  = ctrl.flush_id_ex;
    assign hz.flush_ex_mem = ctrl.flush_ex_mem;

    pipeline_hazard_controller_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (any_stall(ctrl)),
        .count (stall_cnt)
    );

    pipeline_hazard_controller_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (redirect),
        .count (flush_cnt)
    );

endmodule
